// File: rtl/char_line_writer.sv
// Producer for the renderer's 40-column text line: edits a shadow buffer from a
// code stream and publishes it to the displayed array only on frame sync.
//
// state  | meaning
// IDLE   | waiting for a code or a frame-sync commit
// EXEC   | applying the latched code to the shadow buffer and cursor
// COMMIT | copying shadow to the displayed line, clearing dirty
module char_line_writer #(
    parameter int         COLS     = 40,
    parameter logic [7:0] MIN_CHAR = 8'd48,
    parameter logic [7:0] MAX_CHAR = 8'd90
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    input  logic       frame_sync,
    output logic [7:0] character [0:COLS],
    output logic [5:0] cursor,
    output logic       dirty,
    output logic       overflow,
    output logic       bad_code
);

    localparam logic [5:0] LAST = 6'(COLS);

    typedef enum logic [1:0] {IDLE, EXEC, COMMIT} state_t;

    state_t     state, state_n;
    logic [7:0] code_q;
    logic [7:0] shadow [0:COLS-1];
    logic       accept;
    logic       is_print, is_space, is_bs, is_cr;
    logic       room, edit_dirty, dirty_post;

    always_comb begin
        is_print   = (code_q >= MIN_CHAR) && (code_q <= MAX_CHAR);
        is_space   = (code_q == 8'h20);
        is_bs      = (code_q == 8'h08);
        is_cr      = (code_q == 8'h0D);
        room       = (cursor < LAST);
        edit_dirty = ((is_print || is_space) && room) || (is_bs && (cursor != 6'd0)) || is_cr;
        dirty_post = dirty || edit_dirty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // A frame_sync seen during EXEC is the pending commit; it is judged on the post-edit dirty.
    always_comb begin
        state_n  = state;
        in_ready = (state == IDLE) && !frame_sync;
        accept   = in_valid && in_ready;
        unique case (state)
            IDLE: begin
                if (frame_sync && dirty) state_n = COMMIT;
                else if (accept)         state_n = EXEC;
            end
            EXEC:    state_n = (frame_sync && dirty_post) ? COMMIT : IDLE;
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q   <= 8'd0;
            cursor   <= 6'd0;
            dirty    <= 1'b0;
            overflow <= 1'b0;
            bad_code <= 1'b0;
            for (int i = 0; i < COLS; i++) shadow[i] <= 8'd0;
            for (int i = 0; i <= COLS; i++) character[i] <= 8'd0;
        end else begin
            overflow <= 1'b0;
            bad_code <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) code_q <= in_char;
                end
                EXEC: begin
                    dirty <= dirty_post;
                    if (is_print || is_space) begin
                        if (room) begin
                            shadow[cursor] <= is_space ? 8'd0 : code_q;
                            cursor         <= cursor + 6'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else if (is_bs) begin
                        if (cursor != 6'd0) begin
                            shadow[cursor - 6'd1] <= 8'd0;
                            cursor                <= cursor - 6'd1;
                        end
                    end else if (is_cr) begin
                        for (int i = 0; i < COLS; i++) shadow[i] <= 8'd0;
                        cursor <= 6'd0;
                    end else begin
                        bad_code <= 1'b1;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < COLS; i++) character[i] <= shadow[i];
                    character[COLS] <= 8'd0;
                    dirty           <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_char_line_writer.sv
// Scoreboard bench for char_line_writer: a line-editor model predicts pulses and
// committed lines; a monitor pops and compares them when they become due.
module tb_char_line_writer;

    localparam int COLS = 40;
    localparam int LW   = 8 * (COLS + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_char = 8'd0;
    logic       frame_sync = 1'b0;
    logic       in_ready;
    logic [7:0] character [0:COLS];
    logic [5:0] cursor;
    logic       dirty, overflow, bad_code;

    char_line_writer #(.COLS(COLS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char),
        .in_ready(in_ready), .frame_sync(frame_sync), .character(character),
        .cursor(cursor), .dirty(dirty), .overflow(overflow), .bad_code(bad_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ov_cnt = 0;
    int bad_cnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) if (!rst) begin
        ov_cnt  += int'(overflow);
        bad_cnt += int'(bad_code);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] pack_dut();
        logic [LW-1:0] r;
        for (int i = 0; i <= COLS; i++) r[i*8 +: 8] = character[i];
        return r;
    endfunction

    // ---------------- reference model: a plain line editor with a phase tracker
    typedef struct { int due; bit ov; bit bad; } pulse_t;
    typedef struct { int due; logic [LW-1:0] line; int cur; } commit_t;
    pulse_t  pq[$];
    commit_t cq[$];

    int         m_phase;   // 0 waiting, 1 editing, 2 publishing
    logic [7:0] m_code;
    logic [7:0] m_shadow [COLS];
    int         m_cursor;
    bit         m_dirty;

    task automatic m_edit(output bit ov, output bit bad);
        int c;
        c = int'(m_code);
        ov = 0;
        bad = 0;
        if (c >= 48 && c <= 90 || c == 32) begin
            if (m_cursor < COLS) begin
                m_shadow[m_cursor] = (c == 32) ? 8'd0 : m_code;
                m_cursor++;
                m_dirty = 1;
            end else ov = 1;
        end else if (c == 8) begin
            if (m_cursor > 0) begin
                m_cursor--;
                m_shadow[m_cursor] = 8'd0;
                m_dirty = 1;
            end
        end else if (c == 13) begin
            for (int i = 0; i < COLS; i++) m_shadow[i] = 8'd0;
            m_cursor = 0;
            m_dirty = 1;
        end else bad = 1;
    endtask

    always @(negedge clk) begin
        bit ov, bad;
        logic [LW-1:0] line;
        if (rst) begin
            m_phase = 0;
            m_cursor = 0;
            m_dirty = 0;
            for (int i = 0; i < COLS; i++) m_shadow[i] = 8'd0;
            pq.delete();
            cq.delete();
        end else begin
            chk("in_ready", int'(in_ready), int'(m_phase == 0 && !frame_sync));
            case (m_phase)
                0: begin
                    if (frame_sync && m_dirty) m_phase = 2;
                    else if (in_valid && !frame_sync) begin
                        m_code = in_char;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_edit(ov, bad);
                    if (ov || bad) pq.push_back('{cyc + 1, ov, bad});
                    m_phase = (frame_sync && m_dirty) ? 2 : 0;
                end
                default: begin
                    line = '0;
                    for (int i = 0; i < COLS; i++) line[i*8 +: 8] = m_shadow[i];
                    m_dirty = 0;
                    cq.push_back('{cyc + 1, line, m_cursor});
                    m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- monitor
    logic [LW-1:0] prev_line = '0;

    always @(negedge clk) begin
        logic [LW-1:0] cur;
        bit exp_ov, exp_bad;
        pulse_t p;
        commit_t c;
        cur = pack_dut();
        if (!rst) begin
            exp_ov = 0;
            exp_bad = 0;
            if (pq.size() > 0 && pq[0].due <= cyc) begin
                p = pq.pop_front();
                exp_ov = p.ov;
                exp_bad = p.bad;
            end
            if (exp_ov || exp_bad || overflow || bad_code) begin
                chk("overflow", int'(overflow), int'(exp_ov));
                chk("bad_code", int'(bad_code), int'(exp_bad));
            end
            if (cq.size() > 0 && cq[0].due <= cyc) begin
                c = cq.pop_front();
                checks++;
                if (cur != c.line) begin
                    failures++;
                    $display("FAIL commit_line actual=%h required=%h", cur, c.line);
                end
                chk("commit_cursor", int'(cursor), c.cur);
                chk("commit_dirty", int'(dirty), 0);
            end else begin
                checks++;
                if (cur != prev_line) begin
                    failures++;
                    $display("FAIL char_stable actual=%h required=%h", cur, prev_line);
                end
            end
        end
        prev_line = cur;
    end

    // ---------------- stimulus
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_char = c;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 64) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=%0d cycles required=accept", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic fsync();
        frame_sync = 1'b1;
        @(posedge clk);
        #1;
        frame_sync = 1'b0;
    endtask

    function automatic int nonzero_cells(input int from, input int to);
        int n;
        n = 0;
        for (int i = from; i <= to; i++) if (character[i] != 8'd0) n++;
        return n;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int ob, bb, n, r;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cursor", int'(cursor), 0);
        chk("rst_dirty", int'(dirty), 0);
        chk("rst_char", nonzero_cells(0, COLS), 0);
        @(posedge clk); #1;

        // reset while 'B' is in EXEC
        send(8'h41);
        send(8'h42);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cursor", int'(cursor), 0);
        chk("midrst_dirty", int'(dirty), 0);
        chk("midrst_ready", int'(in_ready), 1);
        chk("midrst_char", nonzero_cells(0, COLS), 0);
        @(posedge clk); #1 rst = 1'b0;
        idle(1);

        // "12A" then commit
        send(8'h31); send(8'h32); send(8'h41);
        idle(3);
        chk("pre_sync_char0", int'(character[0]), 0);
        fsync();
        idle(3);
        chk("c12a_0", int'(character[0]), 8'h31);
        chk("c12a_1", int'(character[1]), 8'h32);
        chk("c12a_2", int'(character[2]), 8'h41);
        chk("c12a_rest", nonzero_cells(3, COLS), 0);
        chk("c12a_cursor", int'(cursor), 3);
        chk("c12a_dirty", int'(dirty), 0);

        // 41 x 'Z'
        send(8'h0D);
        ob = ov_cnt;
        repeat (41) send(8'h5A);
        idle(3);
        chk("z41_overflows", ov_cnt - ob, 1);
        chk("z41_cursor", int'(cursor), 40);
        fsync();
        idle(3);
        n = 0;
        for (int i = 0; i < COLS; i++) if (character[i] == 8'h5A) n++;
        chk("z41_cells", n, COLS);
        chk("z41_last", int'(character[COLS]), 0);

        // CR after full line, commit pending from EXEC
        send(8'h0D);
        fsync();
        idle(3);
        chk("cr_char", nonzero_cells(0, COLS), 0);
        chk("cr_cursor", int'(cursor), 0);

        // backspace editing
        ob = ov_cnt;
        bb = bad_cnt;
        send(8'h08);
        idle(3);
        chk("bs0_pulses", (ov_cnt - ob) + (bad_cnt - bb), 0);
        chk("bs0_cursor", int'(cursor), 0);
        send(8'h41); send(8'h42); send(8'h43); send(8'h08); send(8'h08); send(8'h51);
        fsync();
        idle(3);
        chk("bs_0", int'(character[0]), 8'h41);
        chk("bs_1", int'(character[1]), 8'h51);
        chk("bs_2", int'(character[2]), 0);
        chk("bs_cursor", int'(cursor), 2);

        // in_valid and frame_sync together while dirty
        send(8'h42);
        idle(2);
        in_valid = 1'b1;
        in_char = 8'h58;
        frame_sync = 1'b1;
        @(negedge clk);
        chk("x_ready", int'(in_ready), 0);
        @(posedge clk); #1 frame_sync = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 64);
        chk("x_wait", n, 2);
        @(posedge clk); #1 in_valid = 1'b0;
        idle(3);
        chk("x_cursor", int'(cursor), 4);
        chk("x_dirty", int'(dirty), 1);
        chk("x_commit_2", int'(character[2]), 8'h42);

        // unsupported code
        bb = bad_cnt;
        send(8'h7F);
        idle(3);
        chk("bad_pulses", bad_cnt - bb, 1);
        chk("bad_cursor", int'(cursor), 4);
        chk("bad_dirty", int'(dirty), 1);

        // frame_sync on a clean line does not enter COMMIT
        fsync();
        idle(3);
        frame_sync = 1'b1;
        @(posedge clk); #1 frame_sync = 1'b0;
        @(negedge clk);
        chk("clean_fs_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 15));
            in_valid = ($urandom_range(0, 2) != 0);
            if (r <= 8)       in_char = 8'(48 + $urandom_range(0, 42));
            else if (r <= 10) in_char = 8'h20;
            else if (r == 11) in_char = 8'h08;
            else if (r == 12) in_char = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'h5A;
            else              in_char = 8'($urandom_range(0, 255));
            frame_sync = ($urandom_range(0, 9) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        frame_sync = 1'b0;
        idle(6);
        chk("queues_drained", pq.size() + cq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
